// File: rtl/hbus_arb.sv
`default_nettype none
// ============================================================================
// Module      : hbus_arb
// Description : Shared hart memory-port responder. Round-robin arbitration of
//               line reads/writes onto one memory port, fill-data return on
//               per-hart h_dv strobes, post-write invalidation broadcast, and
//               ownership of the AMO lock.
// Revision    : 1.0 - initial release
// ============================================================================
module hbus_arb #(
    parameter int N_HARTS = 2,
    parameter int LINE_W  = 256
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [64*N_HARTS-1:0]     h_addr,
    input  logic [N_HARTS-1:0]        h_rd,
    input  logic [N_HARTS-1:0]        h_wr,
    input  logic [LINE_W*N_HARTS-1:0] h_data_out,
    output logic [LINE_W-1:0]         h_data_in,
    output logic [N_HARTS-1:0]        h_dv,
    output logic [63:0]               h_inv_addr,
    output logic [N_HARTS-1:0]        h_inv,
    input  logic [N_HARTS-1:0]        h_amo_req,
    output logic [N_HARTS-1:0]        h_amo_ack,
    output logic [63:0]               m_addr,
    output logic                      m_rd,
    output logic                      m_wr,
    output logic [LINE_W-1:0]         m_data_out,
    input  logic [LINE_W-1:0]         m_data_in,
    input  logic                      m_dv
);

    localparam int          c_PTR_W     = (N_HARTS > 1) ? $clog2(N_HARTS) : 1;
    localparam int          c_OFF_W     = $clog2(LINE_W / 8);
    localparam logic [63:0] c_LINE_MASK = ~((64'd1 << c_OFF_W) - 64'd1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_INV  = 2'd3
    } state_t;

    state_t               r_state;
    logic [c_PTR_W-1:0]   r_rr_ptr;
    logic [c_PTR_W-1:0]   r_win;
    logic                 r_is_wr;
    logic [63:0]          r_addr;
    logic [LINE_W-1:0]    r_wdata;
    logic [LINE_W-1:0]    r_rdata;
    logic [N_HARTS-1:0]   r_dv;
    logic [N_HARTS-1:0]   r_inv;
    logic [63:0]          r_inv_addr;
    logic                 r_m_rd;
    logic                 r_m_wr;
    logic                 r_lock_busy;
    logic [c_PTR_W-1:0]   r_lock_owner;
    logic [N_HARTS-1:0]   r_amo_ack;
    // Set after a hart's writeback completes while it still holds h_rd,
    // so its next grant is the read half of the pair.
    logic [N_HARTS-1:0]   r_wb_done;

    logic [N_HARTS-1:0]   w_elig;
    logic                 w_any;
    logic [c_PTR_W-1:0]   w_win;
    logic [c_PTR_W-1:0]   w_idx;
    logic [c_PTR_W-1:0]   w_next_ptr;
    logic [63:0]          w_sel_addr;
    logic [LINE_W-1:0]    w_sel_data;
    logic                 w_sel_wr;
    logic                 w_amo_any;
    logic [c_PTR_W-1:0]   w_amo_low;
    logic                 w_owner_drop;
    logic [N_HARTS-1:0]   w_inv_mask;

    // A hart may compete when it has a request and the lock does not exclude it.
    for (genvar gi = 0; gi < N_HARTS; gi++) begin : g_elig
        assign w_elig[gi] = (h_rd[gi] | h_wr[gi]) &
                            (~r_lock_busy | (r_lock_owner == c_PTR_W'(gi)));
    end

    // Round-robin search for the first eligible hart at or after the pointer.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        w_idx = '0;
        for (int k = 0; k < N_HARTS; k++) begin
            w_idx = c_PTR_W'((int'(r_rr_ptr) + k) % N_HARTS);
            if (!w_any && w_elig[w_idx]) begin
                w_any = 1'b1;
                w_win = w_idx;
            end
        end
    end

    assign w_next_ptr = c_PTR_W'((int'(w_win) + 1) % N_HARTS);
    assign w_sel_addr = h_addr[64*int'(w_win) +: 64];
    assign w_sel_data = h_data_out[LINE_W*int'(w_win) +: LINE_W];
    // Writeback goes first when a hart presents both a read and a write.
    assign w_sel_wr   = h_wr[w_win] & ~r_wb_done[w_win];

    // Lowest-index AMO requester, used when the lock is (becoming) free.
    always_comb begin
        w_amo_any = |h_amo_req;
        w_amo_low = '0;
        for (int k = N_HARTS - 1; k >= 0; k--) begin
            if (h_amo_req[k]) begin
                w_amo_low = c_PTR_W'(k);
            end
        end
    end

    assign w_owner_drop = r_lock_busy & ~h_amo_req[r_lock_owner];

    // Everyone except the writer gets the invalidate; empty for one hart.
    always_comb begin
        w_inv_mask        = '1;
        w_inv_mask[r_win] = 1'b0;
    end

    // AMO lock: release on owner drop; new grants only while the FSM is idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock_busy  <= 1'b0;
            r_lock_owner <= '0;
            r_amo_ack    <= '0;
        end else if ((~r_lock_busy | w_owner_drop) && (r_state == S_IDLE) && w_amo_any) begin
            r_lock_busy            <= 1'b1;
            r_lock_owner           <= w_amo_low;
            r_amo_ack              <= '0;
            r_amo_ack[w_amo_low]   <= 1'b1;
        end else if (w_owner_drop) begin
            r_lock_busy <= 1'b0;
            r_amo_ack   <= '0;
        end
    end

    // Track which harts have finished the writeback half of a rd+wr pair.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_done <= '0;
        end else begin
            for (int i = 0; i < N_HARTS; i++) begin
                if (!(h_rd[i] && h_wr[i])) begin
                    r_wb_done[i] <= 1'b0;
                end
            end
            if (r_state == S_RESP) begin
                r_wb_done[r_win] <= r_is_wr & h_rd[r_win] & h_wr[r_win];
            end
        end
    end

    // Transaction FSM: grant, memory request, hart response, invalidate.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= '0;
            r_win      <= '0;
            r_is_wr    <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_dv       <= '0;
            r_inv      <= '0;
            r_inv_addr <= '0;
            r_m_rd     <= 1'b0;
            r_m_wr     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_win    <= w_win;
                        r_rr_ptr <= w_next_ptr;
                        r_is_wr  <= w_sel_wr;
                        r_addr   <= w_sel_addr & c_LINE_MASK;
                        r_wdata  <= w_sel_wr ? w_sel_data : '0;
                        r_m_rd   <= ~w_sel_wr;
                        r_m_wr   <= w_sel_wr;
                        r_state  <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (m_dv) begin
                        r_m_rd       <= 1'b0;
                        r_m_wr       <= 1'b0;
                        if (!r_is_wr) begin
                            r_rdata <= m_data_in;
                        end
                        r_dv[r_win]  <= 1'b1;
                        r_state      <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_dv <= '0;
                    if (r_is_wr) begin
                        r_inv      <= w_inv_mask;
                        r_inv_addr <= r_addr;
                        r_state    <= S_INV;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_INV: begin
                    r_inv   <= '0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign h_data_in  = r_rdata;
    assign h_dv       = r_dv;
    assign h_inv      = r_inv;
    assign h_inv_addr = r_inv_addr;
    assign h_amo_ack  = r_amo_ack;
    assign m_addr     = r_addr;
    assign m_rd       = r_m_rd;
    assign m_wr       = r_m_wr;
    assign m_data_out = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_hbus_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_hbus_arb
// Description : Self-checking bench for hbus_arb (2 harts, 256-bit lines).
//               Stimulus pushes expected memory/response/invalidate events;
//               a monitor pops and compares them as the DUT presents them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hbus_arb;

    localparam int N  = 2;
    localparam int LW = 256;
    localparam int K_MEM = 0;
    localparam int K_DV  = 1;
    localparam int K_INV = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [64*N-1:0]   h_addr;
    logic [N-1:0]      h_rd;
    logic [N-1:0]      h_wr;
    logic [LW*N-1:0]   h_data_out;
    logic [LW-1:0]     h_data_in;
    logic [N-1:0]      h_dv;
    logic [63:0]       h_inv_addr;
    logic [N-1:0]      h_inv;
    logic [N-1:0]      h_amo_req;
    logic [N-1:0]      h_amo_ack;
    logic [63:0]       m_addr;
    logic              m_rd;
    logic              m_wr;
    logic [LW-1:0]     m_data_out;
    logic [LW-1:0]     m_data_in;
    logic              m_dv;

    int                mem_lat;
    bit                force_dv;
    logic [LW-1:0]     mem_rdata;

    typedef struct {
        int            kind;
        int            hart;
        logic          is_wr;
        logic [63:0]   addr;
        logic [LW-1:0] data;
        logic [N-1:0]  mask;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    hbus_arb #(.N_HARTS(N), .LINE_W(LW)) dut (
        .clk        (clk),
        .rst        (rst),
        .h_addr     (h_addr),
        .h_rd       (h_rd),
        .h_wr       (h_wr),
        .h_data_out (h_data_out),
        .h_data_in  (h_data_in),
        .h_dv       (h_dv),
        .h_inv_addr (h_inv_addr),
        .h_inv      (h_inv),
        .h_amo_req  (h_amo_req),
        .h_amo_ack  (h_amo_ack),
        .m_addr     (m_addr),
        .m_rd       (m_rd),
        .m_wr       (m_wr),
        .m_data_out (m_data_out),
        .m_data_in  (m_data_in),
        .m_dv       (m_dv)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [LW-1:0] act, logic [LW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    function automatic void push_mem(int h, logic w, logic [63:0] a, logic [LW-1:0] d);
        exp_t e;
        e.kind = K_MEM; e.hart = h; e.is_wr = w; e.addr = a; e.data = d; e.mask = '0;
        q.push_back(e);
    endfunction

    function automatic void push_dv(int h, logic w, logic [LW-1:0] d);
        exp_t e;
        e.kind = K_DV; e.hart = h; e.is_wr = w; e.addr = '0; e.data = d; e.mask = '0;
        q.push_back(e);
    endfunction

    function automatic void push_inv(logic [N-1:0] m, logic [63:0] a);
        exp_t e;
        e.kind = K_INV; e.hart = 0; e.is_wr = 1'b1; e.addr = a; e.data = '0; e.mask = m;
        q.push_back(e);
    endfunction

    task automatic pop_exp(input int kind, input string what, output exp_t e, output bit ok);
        if (q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_%s: actual=event required=none", what);
            ok = 1'b0;
            e.kind = -1; e.hart = 0; e.is_wr = 1'b0; e.addr = '0; e.data = '0; e.mask = '0;
        end else begin
            e  = q.pop_front();
            ok = 1'b1;
            chk({what, "_kind"}, LW'(e.kind), LW'(kind));
        end
    endtask

    // Memory model: responds after mem_lat cycles of a held request.
    initial begin
        int cnt;
        cnt       = 0;
        m_dv      = 1'b0;
        m_data_in = '0;
        forever begin
            @(negedge clk);
            if (force_dv) begin
                m_dv = 1'b1;
            end else if (m_rd || m_wr) begin
                if (cnt >= mem_lat) begin
                    m_dv      = 1'b1;
                    m_data_in = mem_rdata;
                    cnt       = 0;
                end else begin
                    m_dv = 1'b0;
                    cnt++;
                end
            end else begin
                m_dv = 1'b0;
                cnt  = 0;
            end
        end
    end

    // Monitor: compare every presented event against the scoreboard.
    initial begin
        exp_t e;
        bit   ok;
        bit   prev_req;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if ((m_rd || m_wr) && !prev_req) begin
                pop_exp(K_MEM, "mem", e, ok);
                if (ok) begin
                    chk("mem_wr", LW'(m_wr), LW'(e.is_wr));
                    chk("mem_rd", LW'(m_rd), LW'(!e.is_wr));
                    chk("mem_addr", LW'(m_addr), LW'(e.addr));
                    if (e.is_wr) chk("mem_wdata", m_data_out, e.data);
                end
            end
            prev_req = m_rd || m_wr;
            if (h_dv != '0) begin
                chk("dv_inv_overlap", LW'(h_dv & h_inv), LW'(0));
                pop_exp(K_DV, "dv", e, ok);
                if (ok) begin
                    chk("dv_hart", LW'(h_dv), LW'(N'(1) << e.hart));
                    if (!e.is_wr) chk("dv_rdata", h_data_in, e.data);
                end
            end
            if (h_inv != '0) begin
                pop_exp(K_INV, "inv", e, ok);
                if (ok) begin
                    chk("inv_mask", LW'(h_inv), LW'(e.mask));
                    chk("inv_addr", LW'(h_inv_addr), LW'(e.addr));
                end
            end
        end
    end

    task automatic wait_dv(input int h, input int n, input int budget);
        int cnt;
        cnt = 0;
        for (int c = 0; c < budget && cnt < n; c++) begin
            @(negedge clk);
            if (h_dv[h]) cnt++;
        end
        if (cnt < n) begin
            n_checks++;
            n_errors++;
            $display("FAIL timeout_dv_hart%0d: actual=%0d pulses required=%0d", h, cnt, n);
        end
    endtask

    task automatic check_all_zero(string tag);
        chk({tag, "_h_dv"},       LW'(h_dv), LW'(0));
        chk({tag, "_h_inv"},      LW'(h_inv), LW'(0));
        chk({tag, "_h_inv_addr"}, LW'(h_inv_addr), LW'(0));
        chk({tag, "_h_amo_ack"},  LW'(h_amo_ack), LW'(0));
        chk({tag, "_m_rd_wr"},    LW'({m_rd, m_wr}), LW'(0));
        chk({tag, "_m_addr"},     LW'(m_addr), LW'(0));
        chk({tag, "_m_data_out"}, m_data_out, LW'(0));
        chk({tag, "_h_data_in"},  h_data_in, LW'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen;
        rst        = 1'b1;
        h_rd       = '0;
        h_wr       = '0;
        h_addr     = '0;
        h_data_out = '0;
        h_amo_req  = '0;
        force_dv   = 1'b0;
        mem_lat    = 0;
        mem_rdata  = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Reset while a read is waiting on memory, with m_dv forced high.
        mem_lat = 20;
        push_mem(0, 1'b0, 64'h7000, '0);
        h_addr[63:0] = 64'h7008;
        h_rd[0] = 1'b1;
        seen = 0;
        for (int c = 0; c < 10 && seen == 0; c++) begin
            @(negedge clk);
            if (m_rd) seen = 1;
        end
        chk("rst_mid_req_started", LW'(seen), LW'(1));
        @(negedge clk);
        rst      = 1'b1;
        force_dv = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("rst_mid_req");
        h_rd[0]  = 1'b0;
        rst      = 1'b0;
        force_dv = 1'b0;
        repeat (2) @(negedge clk);

        // Single read from hart0, memory two cycles after m_rd.
        mem_lat   = 2;
        mem_rdata = {32{8'hA5}};
        push_mem(0, 1'b0, 64'h8000_0000, '0);
        push_dv(0, 1'b0, {32{8'hA5}});
        h_addr[63:0] = 64'h8000_0013;
        h_rd[0] = 1'b1;
        @(negedge clk);
        chk("read_m_rd_latency", LW'(m_rd), LW'(1));
        chk("read_m_addr_aligned", LW'(m_addr), LW'(64'h8000_0000));
        wait_dv(0, 1, 20);
        h_rd[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("read_data_held", h_data_in, {32{8'hA5}});

        // Write from hart1 followed by an invalidate to hart0.
        mem_lat = 1;
        h_addr[127:64]     = 64'h1040;
        h_data_out[511:256] = {8{32'h1111_2222}};
        push_mem(1, 1'b1, 64'h1040, {8{32'h1111_2222}});
        push_dv(1, 1'b1, '0);
        push_inv(2'b01, 64'h1040);
        h_wr[1] = 1'b1;
        wait_dv(1, 1, 20);
        h_wr[1] = 1'b0;
        @(negedge clk);
        chk("write_inv_next_cycle", LW'(h_inv), LW'(2'b01));
        repeat (2) @(negedge clk);

        // Round-robin with both harts requesting continuously, zero-wait memory.
        mem_lat   = 0;
        mem_rdata = {8{32'hC0DE_0000}};
        for (int r = 0; r < 2; r++) begin
            push_mem(0, 1'b0, 64'h2000, '0);
            push_dv(0, 1'b0, {8{32'hC0DE_0000}});
            push_mem(1, 1'b0, 64'h3000, '0);
            push_dv(1, 1'b0, {8{32'hC0DE_0000}});
        end
        h_addr[63:0]   = 64'h2000;
        h_addr[127:64] = 64'h3000;
        h_rd = 2'b11;
        seen = 0;
        for (int c = 0; c < 60 && seen < 4; c++) begin
            @(negedge clk);
            if (h_dv != '0) seen++;
        end
        h_rd = 2'b00;
        chk("rr_grant_count", LW'(seen), LW'(4));
        repeat (3) @(negedge clk);

        // AMO lock held by hart0 blocks hart1 until released.
        h_amo_req[0] = 1'b1;
        @(negedge clk);
        chk("amo_ack_hart0", LW'(h_amo_ack), LW'(2'b01));
        h_addr[127:64] = 64'h4000;
        h_rd[1] = 1'b1;
        repeat (3) @(negedge clk);
        chk("amo_hart1_blocked", LW'(m_rd), LW'(0));
        mem_lat   = 1;
        mem_rdata = {8{32'h5555_AAAA}};
        push_mem(0, 1'b0, 64'h5000, '0);
        push_dv(0, 1'b0, {8{32'h5555_AAAA}});
        h_addr[63:0] = 64'h5000;
        h_rd[0] = 1'b1;
        wait_dv(0, 1, 20);
        h_rd[0] = 1'b0;
        h_addr[63:0]     = 64'h5040;
        h_data_out[255:0] = {8{32'hDEAD_BEEF}};
        push_mem(0, 1'b1, 64'h5040, {8{32'hDEAD_BEEF}});
        push_dv(0, 1'b1, '0);
        push_inv(2'b10, 64'h5040);
        h_wr[0] = 1'b1;
        wait_dv(0, 1, 20);
        h_wr[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("amo_still_blocked", LW'({m_rd, m_wr}), LW'(0));
        chk("amo_ack_held", LW'(h_amo_ack), LW'(2'b01));
        mem_rdata = {8{32'h4444_0000}};
        push_mem(1, 1'b0, 64'h4000, '0);
        push_dv(1, 1'b0, {8{32'h4444_0000}});
        h_amo_req[0] = 1'b0;
        @(negedge clk);
        chk("amo_ack_released", LW'(h_amo_ack), LW'(0));
        wait_dv(1, 1, 20);
        h_rd[1] = 1'b0;
        repeat (2) @(negedge clk);

        // Same hart presents read and write together: writeback first.
        mem_lat   = 1;
        mem_rdata = {8{32'h600D_CAFE}};
        h_addr[63:0]      = 64'h6000;
        h_data_out[255:0] = {8{32'h0BAD_F00D}};
        push_mem(0, 1'b1, 64'h6000, {8{32'h0BAD_F00D}});
        push_dv(0, 1'b1, '0);
        push_inv(2'b10, 64'h6000);
        push_mem(0, 1'b0, 64'h6000, '0);
        push_dv(0, 1'b0, {8{32'h600D_CAFE}});
        h_rd[0] = 1'b1;
        h_wr[0] = 1'b1;
        wait_dv(0, 2, 40);
        h_rd[0] = 1'b0;
        h_wr[0] = 1'b0;

        for (int c = 0; c < 20 && q.size() != 0; c++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", LW'(q.size()), LW'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
